// File: rtl/enc_sched_pkg.sv
// Shared constants and types for the ECC encoder request scheduler:
// width codes, FSM state encoding and the MSB-alignment helper.
package enc_sched_pkg;

    localparam logic [1:0] W_SMALL   = 2'b00;
    localparam logic [1:0] W_MEDIUM  = 2'b01;
    localparam logic [1:0] W_LARGE   = 2'b10;
    localparam logic [1:0] W_INVALID = 2'b11;

    localparam int SH_SMALL  = 28;
    localparam int SH_MEDIUM = 21;
    localparam int SH_LARGE  = 6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Payload is right-justified; the encoder wants it MSB-aligned with zero low bits.
    function automatic logic [31:0] align_data(input logic [25:0] data, input logic [1:0] width);
        logic [31:0] r;
        r = '0;
        case (width)
            W_SMALL:  r = 32'(data[3:0]) << SH_SMALL;
            W_MEDIUM: r = 32'(data[10:0]) << SH_MEDIUM;
            W_LARGE:  r = 32'(data[25:0]) << SH_LARGE;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/enc_rr_arbiter.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is granted.
module enc_rr_arbiter (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = valid0 && (!valid1 || last_grant);
    assign gnt1 = valid1 && (!valid0 || !last_grant);

endmodule

// File: rtl/enc_req_scheduler.sv
// Shares one ECC encoder between a register-path and a DMA-path requester, one operation in flight.
// Optional per-requester completion counters cnt0/cnt1 are built when ENC_SCHED_STATS_EN is defined.
//
//  state   | meaning
//  S_IDLE  | ready offered to the granted requester, waiting for a request
//  S_ISSUE | first cycle of encoder inputs driven from latched request
//  S_WAIT  | encoder latency; codeword captured on the last cycle
//  S_RESP  | response held on the owner's channel until accepted
module enc_req_scheduler
    import enc_sched_pkg::*;
#(
    parameter int ENC_LATENCY = 1
`ifdef ENC_SCHED_STATS_EN
    ,
    parameter int CNT_WIDTH = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [25:0] req0_data,
    input  logic [1:0]  req0_width,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [25:0] req1_data,
    input  logic [1:0]  req1_width,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_code,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_code,
    output logic        rsp1_err,
    output logic [31:0] enc_data,
    output logic        enc_small,
    output logic        enc_medium,
    output logic        enc_large,
    input  logic [31:0] enc_out
`ifdef ENC_SCHED_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] cnt0,
    output logic [CNT_WIDTH-1:0] cnt1
`endif
);

    localparam int WCW = (ENC_LATENCY > 1) ? $clog2(ENC_LATENCY) : 1;

    state_e      state_q, state_d;
    logic [25:0] data_q;
    logic [1:0]  width_q;
    logic        owner_q;
    logic        last_grant_q;
    logic [31:0] code_q;
    logic        err_q;
    logic [WCW-1:0] wait_cnt_q;

    logic        gnt0, gnt1;
    logic        acc, acc_owner;
    logic [25:0] acc_data;
    logic [1:0]  acc_width;
    logic        wait_done, rsp_hs, enc_active;

    enc_rr_arbiter u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign req0_ready = rst && (state_q == S_IDLE) && gnt0;
    assign req1_ready = rst && (state_q == S_IDLE) && gnt1;

    assign acc       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign acc_owner = req1_ready;
    assign acc_data  = acc_owner ? req1_data  : req0_data;
    assign acc_width = acc_owner ? req1_width : req0_width;

    assign wait_done  = (state_q == S_WAIT) && (wait_cnt_q == '0);
    assign rsp_hs     = (state_q == S_RESP) && (owner_q ? rsp1_ready : rsp0_ready);
    assign enc_active = (state_q == S_ISSUE) || (state_q == S_WAIT);

    assign enc_data   = enc_active ? align_data(data_q, width_q) : '0;
    assign enc_small  = enc_active && (width_q == W_SMALL);
    assign enc_medium = enc_active && (width_q == W_MEDIUM);
    assign enc_large  = enc_active && (width_q == W_LARGE);

    assign rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign rsp1_valid = (state_q == S_RESP) && owner_q;
    assign rsp0_code  = rsp0_valid ? code_q : '0;
    assign rsp1_code  = rsp1_valid ? code_q : '0;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    state_d = (acc_width == W_INVALID) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (wait_done) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q       <= '0;
            width_q      <= W_SMALL;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            code_q       <= '0;
            err_q        <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            if (acc) begin
                data_q       <= acc_data;
                width_q      <= acc_width;
                owner_q      <= acc_owner;
                last_grant_q <= acc_owner;
                code_q       <= '0;
                err_q        <= (acc_width == W_INVALID);
            end
            if (state_q == S_ISSUE) begin
                wait_cnt_q <= WCW'(ENC_LATENCY - 1);
            end else if ((state_q == S_WAIT) && (wait_cnt_q != '0)) begin
                wait_cnt_q <= wait_cnt_q - 1'b1;
            end
            if (wait_done) begin
                code_q <= enc_out;
            end
        end
    end

`ifdef ENC_SCHED_STATS_EN
    logic good_hs;
    assign good_hs = rsp_hs && !err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (good_hs) begin
            if (!owner_q && (cnt0 != '1)) begin
                cnt0 <= cnt0 + CNT_WIDTH'(1);
            end
            if (owner_q && (cnt1 != '1)) begin
                cnt1 <= cnt1 + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule
